// File: rtl/data_mem_lsu.sv
// rtl/data_mem_lsu.sv - synchronous byte/half/word data memory with load-store unit
//
// Purpose: one-port data memory between EX/MEM and MEM/WB. Requests are
// accepted in READY, answered exactly one cycle later. After reset the
// whole array is zero-filled, one word per cycle, before READY is entered.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   req_valid / req_ready     request handshake (ready only in READY)
//   req_we, req_size, req_uns store flag, 00 byte/01 half/10 word, zero-extend
//   req_addr, req_wdata       byte address, store data (low bits for byte/half)
//   rsp_valid                 one-cycle pulse, response to last accepted request
//   rsp_rdata                 extended load data; 0 for stores and errors
//   rsp_err                   [0] misaligned/illegal size, [1] out of range
module data_mem_lsu #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err
);

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e        state_q;
    logic [AW-1:0] clr_idx_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic [1:0]    rsp_err_q;
    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word;
    logic [1:0]    lane;
    logic          out_of_range;
    logic          misaligned;
    logic [1:0]    err;
    logic          accept;
    logic          store_en;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;

    assign word         = req_addr[AW+1:2];
    assign lane         = req_addr[1:0];
    // Any set bit above the array's byte range is out of range.
    assign out_of_range = |(req_addr >> (AW + 2));
    assign misaligned   = (req_size == 2'b01 && lane[0])
                       || (req_size == 2'b10 && lane != 2'b00)
                       || (req_size == 2'b11);
    assign err          = {out_of_range, misaligned};

    assign accept   = req_valid && req_ready_q;
    assign store_en = accept && req_we && (err == 2'b00);

    // Replicate store data across lanes; the byte enables pick which land.
    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                lane_be    = 4'b0001 << lane;
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                lane_be    = 4'b0011 << lane;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            default: lane_be = 4'b1111;
        endcase
    end

    assign rd_word = mem_q[word];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (req_size)
            2'b00:   load_data = req_uns ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = req_uns ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Array has no reset of its own; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ST_CLEAR) begin
            mem_q[clr_idx_q] <= 32'b0;
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_be[b]) begin
                    mem_q[word][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 2'b00;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    rsp_valid_q <= 1'b0;
                    clr_idx_q   <= clr_idx_q + AW'(1);
                    if (clr_idx_q == AW'(DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    rsp_valid_q <= accept;
                    if (accept) begin
                        rsp_err_q   <= err;
                        rsp_rdata_q <= (req_we || err != 2'b00) ? 32'b0 : load_data;
                    end
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb/tb_data_mem_lsu.sv - scoreboard testbench for data_mem_lsu
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    int valid_run = 0;
    int max_run   = 0;

    logic [33:0] exp_q[$];
    string       tag_q[$];

    data_mem_lsu #(.DEPTH(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_uns   (req_uns),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        string       t;
        if (rsp_valid === 1'b1) begin
            valid_run++;
            if (valid_run > max_run) max_run = valid_run;
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 34'd1, 34'd0);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk({t, "_rdata"}, {2'b00, rsp_rdata}, {2'b00, e[31:0]});
                chk({t, "_err"}, {32'b0, rsp_err}, {32'b0, e[33:32]});
            end
        end else begin
            valid_run = 0;
        end
    end

    task automatic issue(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_err);
        chk({tag, "_ready"}, {33'b0, req_ready}, 34'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_uns   = uns;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back({exp_err, exp_rdata});
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int cnt = 0;
        @(negedge clk);
        while (!req_ready && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        chk(tag, 34'(cnt), 34'd1024);
        @(posedge clk); #1;
    endtask

    task automatic sw(input string tag, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] e);
        issue(tag, 1'b1, 2'b10, 1'b0, addr, d, 32'h0, e);
    endtask

    task automatic lw(input string tag, input logic [31:0] addr, input logic [31:0] d, input logic [1:0] e);
        issue(tag, 1'b0, 2'b10, 1'b0, addr, 32'h0, d, e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_uns = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        // T1 reset and clear
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {33'b0, req_ready}, 34'd0);
        chk("rst_valid", {33'b0, rsp_valid}, 34'd0);
        chk("rst_rdata", {2'b0, rsp_rdata}, 34'd0);
        chk("rst_err", {32'b0, rsp_err}, 34'd0);
        rst_n = 1'b1;
        wait_clear("t1_clear_len");
        lw("t1_lw0", 32'h0, 32'h0, 2'b00);
        lw("t1_lw8", 32'h8, 32'h0, 2'b00);
        lw("t1_lwffc", 32'hFFC, 32'h0, 2'b00);
        idle(2);

        // T2 sizes and extension
        sw("t2_sw", 32'h10, 32'h80FF7F01, 2'b00);
        issue("t2_lb", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFFF, 2'b00);
        issue("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 2'b00);
        issue("t2_lh", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 2'b00);
        issue("t2_lhu", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007F01, 2'b00);
        idle(2);

        // T3 partial stores
        sw("t3_sw", 32'h20, 32'h11223344, 2'b00);
        issue("t3_sb", 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 32'h0, 2'b00);
        issue("t3_sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 32'h0, 2'b00);
        lw("t3_lw", 32'h20, 32'hBEEFAA44, 2'b00);
        idle(2);

        // T4 errors, memory unchanged after each
        issue("t4_sh_mis", 1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, 32'h0, 2'b01);
        lw("t4_chk20", 32'h20, 32'hBEEFAA44, 2'b00);
        sw("t4_sw_oor", 32'h1000, 32'hCAFEF00D, 2'b10);
        lw("t4_chk0a", 32'h0, 32'h0, 2'b00);
        issue("t4_size11", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0, 2'b01);
        lw("t4_chk0b", 32'h0, 32'h0, 2'b00);
        lw("t4_lw_both", 32'h1002, 32'h0, 2'b11);
        idle(2);

        // T5 back-to-back with read-after-write
        max_run = 0;
        sw("t5_sw5", 32'h40, 32'h5, 2'b00);
        lw("t5_lw5", 32'h40, 32'h5, 2'b00);
        sw("t5_sw6", 32'h40, 32'h6, 2'b00);
        lw("t5_lw6", 32'h40, 32'h6, 2'b00);
        idle(3);
        chk("t5_run", 34'(max_run), 34'd4);

        // T6 reset colliding with an accepting edge drops the load
        sw("t6_sw", 32'h0, 32'hDEAD, 2'b00);
        lw("t6_lw_pre", 32'h0, 32'hDEAD, 2'b00);
        idle(2);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t6_no_rsp", {33'b0, rsp_valid}, 34'd0);
        chk("t6_ready_low", {33'b0, req_ready}, 34'd0);
        rst_n = 1'b1;
        wait_clear("t6_clear_len");
        lw("t6_lw0", 32'h0, 32'h0, 2'b00);
        idle(3);

        chk("sb_empty", 34'(exp_q.size()), 34'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
